horner_datapath: RTL and testbench



---
 rtl/nla_pkg.sv | 34 +++
 rtl/seq_mul.sv | 90 +++++++++
 rtl/horner_datapath.sv | 104 ++++++++++
 tb/tb_horner_datapath.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nla_pkg.sv
// Shared types and helpers for the polynomial-evaluation datapath.
// Holds default widths, the multiplier state encoding and a generic saturator.
package nla_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_FRAC_W = 12;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIN  = 2'd2
    } mul_state_t;

    // Clamps a wide signed value into the w-bit two's complement range.
    // Callers keep 2*w+1 <= 64 so the wide value never wraps.
    function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] v,
                                                    input int w,
                                                    output logic clamped);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        clamped  = 1'b0;
        sat_to_w = v;
        if (v > hi) begin
            sat_to_w = hi;
            clamped  = 1'b1;
        end else if (v < lo) begin
            sat_to_w = lo;
            clamped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative signed fixed-point multiplier: sign-magnitude radix-2 shift-add,
// one bit per cycle, then round-half-away-from-zero and saturate.
module seq_mul
    import nla_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              abort_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] prod_o,
    output logic              sat_o,
    output mul_state_t        state_o
);

    localparam int PW = 2 * DATA_W;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    mul_state_t         state_q;
    logic [PW-1:0]      mcand_q;
    logic [PW-1:0]      pacc_q;
    logic [PW-1:0]      pacc_nxt;
    logic [PW-1:0]      rounded;
    logic [DATA_W-1:0]  mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;
    logic signed [63:0] signed_v;
    logic               clamp;

    // |-2^(DATA_W-1)| wraps to 2^(DATA_W-1), which is exact as an unsigned value.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        mag = v[DATA_W-1] ? (~v) + DATA_W'(1) : v;
    endfunction

    // The final partial product is rounded on the same edge as the last bit,
    // so done_o marks the edge on which prod_o may be captured.
    always_comb begin
        pacc_nxt = pacc_q;
        if (mplier_q[0]) pacc_nxt = pacc_q + mcand_q;
        rounded  = (pacc_nxt + RND) >> FRAC_W;
        signed_v = sign_q ? -$signed(64'(rounded)) : $signed(64'(rounded));
        clamp    = 1'b0;
        prod_o   = DATA_W'(sat_to_w(signed_v, DATA_W, clamp));
        sat_o    = clamp;
        done_o   = (state_q == MUL_RUN) && (cnt_q == LAST_BIT);
    end

    assign state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            pacc_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        mcand_q  <= {{DATA_W{1'b0}}, mag(a_i)};
                        mplier_q <= mag(b_i);
                        sign_q   <= a_i[DATA_W-1] ^ b_i[DATA_W-1];
                        pacc_q   <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    pacc_q   <= pacc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) state_q <= MUL_FIN;
                end
                MUL_FIN: state_q <= MUL_IDLE;
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/horner_datapath.sv
// One Horner step per term: acc <- sat(acc*x + c), with x from the signal FIFO,
// c from the coefficient ROM and a registered result for the controller.
module horner_datapath
    import nla_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dp_reset_i,
    input  logic              rd_signal_i,
    input  logic [DATA_W-1:0] signal_i,
    input  logic              rd_coeff_i,
    input  logic [DATA_W-1:0] coeff_i,
    input  logic              mul_valid_i,
    output logic              mul_done_o,
    input  logic              add_valid_i,
    output logic              add_done_o,
    input  logic              load_result_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              sat_o
);

    logic [DATA_W-1:0]   x_q;
    logic [DATA_W-1:0]   c_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   prod_q;
    logic                rd_coeff_q;
    logic                mul_fin;
    logic [DATA_W-1:0]   mul_prod;
    logic                mul_sat;
    mul_state_t          mul_state;
    logic signed [DATA_W:0] sum;
    logic [DATA_W-1:0]   add_res;
    logic                add_clamp;
    logic                add_ok;

    seq_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_seq_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .abort_i (dp_reset_i),
        .start_i (mul_valid_i),
        .a_i     (acc_q),
        .b_i     (x_q),
        .done_o  (mul_fin),
        .prod_o  (mul_prod),
        .sat_o   (mul_sat),
        .state_o (mul_state)
    );

    // Handshake: a *_valid_i pulse is a one-cycle request with no ready; it is
    // taken only when the engine is idle (otherwise dropped), and its *_done_o
    // pulse is high for exactly one cycle once the target register holds the result.
    assign add_ok = add_valid_i && (mul_state == MUL_IDLE);

    always_comb begin
        sum       = $signed({prod_q[DATA_W-1], prod_q}) + $signed({c_q[DATA_W-1], c_q});
        add_clamp = 1'b0;
        add_res   = DATA_W'(sat_to_w(64'(sum), DATA_W, add_clamp));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q            <= '0;
            c_q            <= '0;
            acc_q          <= '0;
            prod_q         <= '0;
            rd_coeff_q     <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            mul_done_o     <= 1'b0;
            add_done_o     <= 1'b0;
            sat_o          <= 1'b0;
        end else begin
            rd_coeff_q <= rd_coeff_i;
            if (rd_signal_i) x_q <= signal_i;
            // ROM data arrives one cycle after the read enable.
            if (rd_coeff_q) c_q <= coeff_i;

            if (dp_reset_i) begin
                acc_q          <= '0;
                prod_q         <= '0;
                mul_done_o     <= 1'b0;
                add_done_o     <= 1'b0;
                result_valid_o <= 1'b0;
                sat_o          <= 1'b0;
            end else begin
                mul_done_o <= mul_fin;
                if (mul_fin) prod_q <= mul_prod;
                add_done_o <= add_ok;
                if (add_ok) acc_q <= add_res;
                result_valid_o <= load_result_i;
                if (load_result_i) result_o <= acc_q;
                sat_o <= sat_o | (mul_fin & mul_sat) | (add_ok & add_clamp);
            end
        end
    end

endmodule

// File: tb/tb_horner_datapath.sv
// Directed bench for horner_datapath: Horner polynomial, sign, rounding,
// saturation, protocol and reset cases with hand-computed Q3.12 results.
module tb_horner_datapath;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 12;
    localparam int MUL_LAT = 17;

    logic              clk_i;
    logic              rst_i;
    logic              dp_reset_i;
    logic              rd_signal_i;
    logic [DATA_W-1:0] signal_i;
    logic              rd_coeff_i;
    logic [DATA_W-1:0] coeff_i;
    logic              mul_valid_i;
    logic              mul_done_o;
    logic              add_valid_i;
    logic              add_done_o;
    logic              load_result_i;
    logic [DATA_W-1:0] result_o;
    logic              result_valid_o;
    logic              sat_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] exp_q[$];

    horner_datapath #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .dp_reset_i     (dp_reset_i),
        .rd_signal_i    (rd_signal_i),
        .signal_i       (signal_i),
        .rd_coeff_i     (rd_coeff_i),
        .coeff_i        (coeff_i),
        .mul_valid_i    (mul_valid_i),
        .mul_done_o     (mul_done_o),
        .add_valid_i    (add_valid_i),
        .add_done_o     (add_done_o),
        .load_result_i  (load_result_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .sat_o          (sat_o)
    );

    // Clock / watchdog
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Driver tasks
    task automatic read_signal(input logic [DATA_W-1:0] v);
        rd_signal_i = 1'b1;
        signal_i    = v;
        step();
        rd_signal_i = 1'b0;
        signal_i    = DATA_W'($urandom_range(0, 16'hFFFF));
    endtask

    task automatic read_coeff(input logic [DATA_W-1:0] v);
        rd_coeff_i = 1'b1;
        coeff_i    = DATA_W'($urandom_range(0, 16'hFFFF));
        step();
        rd_coeff_i = 1'b0;
        coeff_i    = v;
        step();
        coeff_i    = DATA_W'($urandom_range(0, 16'hFFFF));
    endtask

    task automatic dp_clear();
        dp_reset_i = 1'b1;
        step();
        dp_reset_i = 1'b0;
    endtask

    // Latency counts the mul_valid_i cycle as 0; window is bounded.
    task automatic run_mul(input int poke_k, input int add_k, input int abort_k, input int rst_k,
                           output int lat, output int nd, output int na);
        mul_valid_i = 1'b1;
        step();
        mul_valid_i = 1'b0;
        lat = -1;
        nd  = 0;
        na  = 0;
        for (int k = 1; k <= 30; k++) begin
            mul_valid_i = (k == poke_k);
            add_valid_i = (k == add_k);
            dp_reset_i  = (k == abort_k);
            rst_i       = (k == rst_k);
            step();
            if (mul_done_o) begin
                nd++;
                if (lat < 0) lat = k + 1;
            end
            if (add_done_o) na++;
            if (k == rst_k) begin
                chk("rst_mid result_o", 32'(result_o), 0);
                chk("rst_mid result_valid_o", 32'(result_valid_o), 0);
                chk("rst_mid mul_done_o", 32'(mul_done_o), 0);
                chk("rst_mid add_done_o", 32'(add_done_o), 0);
                chk("rst_mid sat_o", 32'(sat_o), 0);
            end
        end
        mul_valid_i = 1'b0;
        add_valid_i = 1'b0;
        dp_reset_i  = 1'b0;
        rst_i       = 1'b0;
    endtask

    task automatic mul_ok(input string tag);
        int lat, nd, na;
        run_mul(0, 0, 0, 0, lat, nd, na);
        chk({tag, " latency"}, 32'(lat), MUL_LAT);
        chk({tag, " done count"}, 32'(nd), 1);
    endtask

    task automatic add_op();
        add_valid_i = 1'b1;
        step();
        add_valid_i = 1'b0;
        chk("add_done_o", 32'(add_done_o), 1);
    endtask

    // Scoreboard: expected result queued at request, popped on result_valid_o.
    task automatic load_check(input string tag, input logic [DATA_W-1:0] exp);
        exp_q.push_back(exp);
        load_result_i = 1'b1;
        step();
        load_result_i = 1'b0;
        chk({tag, " result_valid_o"}, 32'(result_valid_o), 1);
        if (result_valid_o) chk(tag, 32'(result_o), 32'(exp_q.pop_front()));
        else void'(exp_q.pop_front());
    endtask

    task automatic set_acc(input logic [DATA_W-1:0] v);
        int lat, nd, na;
        read_coeff(v);
        dp_clear();
        run_mul(0, 0, 0, 0, lat, nd, na);
        add_op();
    endtask

    task automatic check_prod(input string tag, input logic [DATA_W-1:0] exp);
        read_coeff('0);
        add_op();
        load_check(tag, exp);
    endtask

    initial begin
        int lat, nd, na;
        rst_i = 1'b1; dp_reset_i = 1'b0; rd_signal_i = 1'b0; signal_i = '0;
        rd_coeff_i = 1'b0; coeff_i = '0; mul_valid_i = 1'b0; add_valid_i = 1'b0;
        load_result_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        chk("reset result_o", 32'(result_o), 0);
        chk("reset result_valid_o", 32'(result_valid_o), 0);
        chk("reset mul_done_o", 32'(mul_done_o), 0);
        chk("reset add_done_o", 32'(add_done_o), 0);
        chk("reset sat_o", 32'(sat_o), 0);

        // 1.0*x^2 + 2.0*x - 1.0 at x = 0.5 -> 0.25
        read_signal(16'h0800);
        dp_clear();
        read_coeff(16'h1000); mul_ok("poly t0"); add_op();
        read_coeff(16'h2000); mul_ok("poly t1"); add_op();
        step();
        chk("add_done_o pulse width", 32'(add_done_o), 0);
        read_coeff(16'hF000); mul_ok("poly t2"); add_op();
        load_check("poly result", 16'h0400);
        chk("poly sat_o", 32'(sat_o), 0);

        // Simultaneous add and load: result takes pre-add acc (prod 0x1400 + 0x1000)
        read_coeff(16'h1000);
        add_valid_i = 1'b1;
        exp_q.push_back(16'h0400);
        load_result_i = 1'b1;
        step();
        add_valid_i = 1'b0;
        load_result_i = 1'b0;
        chk("add+load result_valid_o", 32'(result_valid_o), 1);
        chk("add+load result_o", 32'(result_o), 32'(exp_q.pop_front()));
        load_check("post add+load", 16'h2400);

        // Sign: -1.5 * 2.0 = -3.0
        set_acc(16'hE800);
        read_signal(16'h2000);
        mul_ok("sign");
        check_prod("sign prod", 16'hD000);

        // Rounding, half away from zero
        set_acc(16'h0001);
        read_signal(16'h0800);
        mul_ok("round pos");
        check_prod("round pos prod", 16'h0001);
        set_acc(16'hFFFF);
        mul_ok("round neg");
        check_prod("round neg prod", 16'hFFFF);
        chk("round sat_o", 32'(sat_o), 0);

        // Most negative operand: -8.0 * 1.0 fits exactly; then add underflows
        set_acc(16'h8000);
        read_signal(16'h1000);
        mul_ok("minneg");
        chk("minneg sat_o", 32'(sat_o), 0);
        check_prod("minneg prod", 16'h8000);
        read_coeff(16'hF000);
        add_op();
        chk("add underflow sat_o", 32'(sat_o), 1);
        load_check("add underflow acc", 16'h8000);

        // Saturation: 7.0 * 7.0 clamps; add then clamps too; dp_reset clears
        set_acc(16'h7000);
        read_signal(16'h7000);
        mul_ok("sat");
        chk("mul sat_o", 32'(sat_o), 1);
        check_prod("sat prod", 16'h7FFF);
        read_coeff(16'h1000);
        add_op();
        load_check("sat add acc", 16'h7FFF);
        chk("sat sticky", 32'(sat_o), 1);
        dp_clear();
        chk("dp_reset sat_o", 32'(sat_o), 0);
        load_check("dp_reset acc", 16'h0000);

        // dp_reset at cycle 5 aborts the multiply
        set_acc(16'h1000);
        read_signal(16'h3000);
        run_mul(0, 0, 5, 0, lat, nd, na);
        chk("abort done count", 32'(nd), 0);
        load_check("abort acc", 16'h0000);

        // mul_valid_i re-pulsed and add_valid_i during MUL_RUN are ignored
        set_acc(16'h1000);
        read_coeff(16'h0200);
        run_mul(5, 3, 0, 0, lat, nd, na);
        chk("repulse latency", 32'(lat), MUL_LAT);
        chk("repulse done count", 32'(nd), 1);
        chk("add during run", 32'(na), 0);
        check_prod("repulse prod", 16'h3000);

        // rst_i mid-multiply, then a fresh multiply completes normally
        run_mul(0, 0, 0, 5, lat, nd, na);
        chk("rst_mid done count", 32'(nd), 0);
        set_acc(16'h1000);
        read_signal(16'h1800);
        mul_ok("post reset");
        check_prod("post reset prod", 16'h1800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
